// File: rtl/cpu_selftest_pkg.sv
// Shared types and constants for the CPU self-test sequencer.
package cpu_selftest_pkg;

    localparam int unsigned CountW  = 8;
    localparam int unsigned RstHold = 2;

    typedef enum logic [3:0] {
        StIdle,
        StCpuRst,
        StFetch,
        StApply,
        StSettlePre,
        StStep,
        StSettlePost,
        StCheck,
        StDone
    } state_e;

    // Address width for a vector ROM of n entries; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_selftest_if.sv
// Vector ROM and CPU-under-test signals seen by the self-test sequencer.
interface cpu_selftest_if
    import cpu_selftest_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_VEC = 8
);
    localparam int unsigned AW = addr_w(NUM_VEC);

    logic [AW-1:0] vec_addr;
    logic [N:0]    vec_sw;
    logic [N-1:0]  vec_exp;
    logic [N-1:0]  vec_mask;
    logic [N:0]    cpu_sw;
    logic          cpu_n_reset;
    logic          cpu_step;
    logic [N-1:0]  cpu_led;

    modport master (
        output vec_addr, cpu_sw, cpu_n_reset, cpu_step,
        input  vec_sw, vec_exp, vec_mask, cpu_led
    );

    modport slave (
        input  vec_addr, cpu_sw, cpu_n_reset, cpu_step,
        output vec_sw, vec_exp, vec_mask, cpu_led
    );

endinterface

// File: rtl/st_settle_counter.sv
// Loadable down-counter; expire pulses for one cycle on the last cycle of the load value.
module st_settle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Count parks at zero after the pulse, so expire stays a single cycle.
    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/cpu_selftest.sv
// Steps a CPU through a vector ROM, one instruction per vector, and tallies LED mismatches.
module cpu_selftest
    import cpu_selftest_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned SETTLE  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    cpu_selftest_if.master               bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CountW-1:0]            err_count,
    output logic [CountW-1:0]            test_count,
    output logic [addr_w(NUM_VEC)-1:0]   first_fail
);

    localparam int unsigned AW       = addr_w(NUM_VEC);
    localparam logic [AW-1:0] LastAddr = AW'(NUM_VEC - 1);
    localparam logic [1:0]    RstLast  = 2'(RstHold - 1);
    localparam int unsigned   SetW     = 4;

    state_e        state_q, state_d;
    logic [1:0]    rst_cnt_q;
    logic [AW-1:0] addr_q;
    logic [N:0]    cpu_sw_q;
    logic [N-1:0]  exp_q;
    logic [N-1:0]  mask_q;
    logic [CountW-1:0] err_q;
    logic [CountW-1:0] tc_q;
    logic [AW-1:0] ff_q;

    logic run_start;
    logic run_abort;
    logic mismatch;
    logic last_vec;
    logic settle_load;
    logic settle_expire;

    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign run_start = !busy && start && !abort;
    assign run_abort = busy && abort;
    assign mismatch  = |((bus.cpu_led ^ exp_q) & mask_q);
    assign last_vec  = (addr_q == LastAddr);

    // Both settle windows are armed on the cycle just before they begin.
    assign settle_load = (state_q == StApply) || (state_q == StStep);

    st_settle_counter #(
        .W (SetW)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .clr      (run_abort),
        .load     (settle_load),
        .load_val (SetW'(SETTLE)),
        .expire   (settle_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= (state_q == StCpuRst) ? rst_cnt_q + 1'b1 : 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (run_start) state_d = StCpuRst;
            StCpuRst:       if (rst_cnt_q == RstLast) state_d = StFetch;
            StFetch:        state_d = StApply;
            StApply:        state_d = StSettlePre;
            StSettlePre:    if (settle_expire) state_d = StStep;
            StStep:         state_d = StSettlePost;
            StSettlePost:   if (settle_expire) state_d = StCheck;
            StCheck:        state_d = last_vec ? StDone : StFetch;
            default:        state_d = StIdle;
        endcase
        if (run_abort) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            cpu_sw_q <= '0;
            exp_q    <= '0;
            mask_q   <= '0;
            err_q    <= '0;
            tc_q     <= '0;
            ff_q     <= '0;
        end else if (run_start) begin
            addr_q   <= '0;
            cpu_sw_q <= '0;
            err_q    <= '0;
            tc_q     <= '0;
            ff_q     <= '0;
        end else if (!run_abort) begin
            if (state_q == StApply) begin
                cpu_sw_q <= bus.vec_sw;
                exp_q    <= bus.vec_exp;
                mask_q   <= bus.vec_mask;
            end
            if (state_q == StCheck) begin
                tc_q <= sat_inc(tc_q);
                if (mismatch) begin
                    err_q <= sat_inc(err_q);
                    if (err_q == '0) ff_q <= addr_q;
                end
                if (!last_vec) addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign bus.vec_addr    = addr_q;
    assign bus.cpu_sw      = cpu_sw_q;
    assign bus.cpu_n_reset = (state_q != StCpuRst);
    assign bus.cpu_step    = (state_q == StStep);

    assign done       = (state_q == StDone);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign test_count = tc_q;
    assign first_fail = ff_q;

endmodule
